// File: rtl/maze_wall_fetch.sv
// maze_wall_fetch: follows the VGA pixel scan, prefetches the wall bits of the
// next tile (centre plus four neighbours) from a synchronous wall-map RAM, and
// presents per-pixel in-tile coordinates and neighbour flags to the renderer
// one clock after (de, px, py).
// Optional feature macro: BORDER_WALL_EN (out-of-map neighbours read as wall).
module maze_wall_fetch #(
  parameter int MAP_W  = 40,
  parameter int MAP_H  = 30,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic              line_start,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_rdata,
  output logic [3:0]        cell_x,
  output logic [3:0]        cell_y,
  output logic              cell_wall,
  output logic              left,
  output logic              top,
  output logic              right,
  output logic              bottom,
  output logic              out_valid,
  output logic              fetch_late
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [5:0] LAST_COL = 6'(MAP_W - 1);
`ifdef BORDER_WALL_EN
  localparam logic BORDER = 1'b1;
`else
  localparam logic BORDER = 1'b0;
`endif

  // Item order within one fetch: 0=centre, 1=left, 2=top, 3=right, 4=bottom.
  function automatic void f_pos(input logic [5:0] c, input logic [5:0] r,
                                input logic [2:0] k, output int nc, output int nr);
    nc = int'(c);
    nr = int'(r);
    case (k)
      3'd1:    nc = nc - 1;
      3'd2:    nr = nr - 1;
      3'd3:    nc = nc + 1;
      3'd4:    nr = nr + 1;
      default: ;
    endcase
  endfunction

  function automatic logic f_ok(input logic [5:0] c, input logic [5:0] r, input logic [2:0] k);
    int nc;
    int nr;
    f_pos(c, r, k, nc, nr);
    return (nc >= 0) && (nc < MAP_W) && (nr >= 0) && (nr < MAP_H);
  endfunction

  function automatic logic [ADDR_W-1:0] f_addr(input logic [5:0] c, input logic [5:0] r,
                                               input logic [2:0] k);
    int nc;
    int nr;
    f_pos(c, r, k, nc, nr);
    return ADDR_W'(nr * MAP_W + nc);
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_idx;
  logic [2:0]        w_nidx;
  logic [5:0]        r_fcol;
  logic [5:0]        r_frow;
  logic [5:0]        w_ncol;
  logic [5:0]        w_nrow;
  logic              w_load;
  logic              w_issue_ok;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_lat_en;
  logic [2:0]        w_lidx;
  logic              w_lat_bit;
  logic [ADDR_W-1:0] r_map_addr;
  logic [4:0]        r_pf;
  logic [4:0]        r_act;
  logic [4:0]        w_src;

  logic [3:0] r_cell_x;
  logic [3:0] r_cell_y;
  logic [4:0] r_flags;
  logic       r_out_valid;
  logic       r_fetch_late;

  logic [5:0] w_col;
  logic [5:0] w_row;
  logic       w_swap;
  logic       w_trig_tile;
  logic       w_busy;
  logic       w_start;
  logic [5:0] w_tcol;

  assign w_col       = px[9:4];
  // py[9] kept in the row so lines beyond 511 fall outside the map.
  assign w_row       = py[9:4];
  assign w_swap      = de && (px[3:0] == 4'd0);
  assign w_trig_tile = w_swap && (w_col < LAST_COL);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = line_start || (w_trig_tile && !w_busy);
  assign w_tcol      = line_start ? 6'd0 : (w_col + 6'd1);
  assign w_src       = w_swap ? r_pf : r_act;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, next issue item/target, and which returning item to capture.
  always_comb begin
    w_next = r_state;
    w_nidx = r_idx;
    w_ncol = r_fcol;
    w_nrow = r_frow;
    w_load = 1'b0;
    if (w_start) begin
      w_next = S_ISSUE;
      w_nidx = 3'd0;
      w_ncol = w_tcol;
      w_nrow = w_row;
      w_load = 1'b1;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (r_idx == 3'd4) begin
            w_next = S_DRAIN;
          end else begin
            w_nidx = r_idx + 3'd1;
            w_load = 1'b1;
          end
        end
        S_DRAIN: w_next = S_IDLE;
        default: ;
      endcase
    end
    w_issue_ok   = f_ok(w_ncol, w_nrow, w_nidx);
    w_issue_addr = f_addr(w_ncol, w_nrow, w_nidx);
    // RAM data arriving this cycle belongs to the item issued one cycle earlier.
    w_lat_en     = !line_start &&
                   (((r_state == S_ISSUE) && (r_idx != 3'd0)) || (r_state == S_DRAIN));
    w_lidx       = (r_state == S_DRAIN) ? 3'd4 : (r_idx - 3'd1);
    w_lat_bit    = f_ok(r_fcol, r_frow, w_lidx) ? map_rdata : BORDER;
  end

  // Fetch datapath: issue address, capture returning bits into the prefetch set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_fcol     <= '0;
      r_frow     <= '0;
      r_map_addr <= '0;
      r_pf       <= '0;
    end else begin
      r_idx  <= w_nidx;
      r_fcol <= w_ncol;
      r_frow <= w_nrow;
      if (w_load && w_issue_ok) r_map_addr <= w_issue_addr;
      if (w_lat_en) begin
        for (int unsigned i = 0; i < 5; i++) begin
          if (w_lidx == 3'(i)) r_pf[i] <= w_lat_bit;
        end
      end
    end
  end

  // Tile swap, registered pixel outputs and the sticky late-fetch flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act        <= '0;
      r_cell_x     <= '0;
      r_cell_y     <= '0;
      r_flags      <= '0;
      r_out_valid  <= 1'b0;
      r_fetch_late <= 1'b0;
    end else begin
      r_out_valid <= de;
      if (w_swap) r_act <= r_pf;
      if (de) begin
        r_cell_x <= px[3:0];
        r_cell_y <= py[3:0];
        r_flags  <= w_src;
      end
      // A tile trigger always coincides with a swap, so one test covers both cases.
      if (w_swap && w_busy) r_fetch_late <= 1'b1;
    end
  end

  assign map_addr   = r_map_addr;
  assign cell_x     = r_cell_x;
  assign cell_y     = r_cell_y;
  assign cell_wall  = r_flags[0];
  assign left       = r_flags[1];
  assign top        = r_flags[2];
  assign right      = r_flags[3];
  assign bottom     = r_flags[4];
  assign out_valid  = r_out_valid;
  assign fetch_late = r_fetch_late;

endmodule

// File: tb/tb_maze_wall_fetch.sv
// Directed bench for maze_wall_fetch with a behavioural sync wall-map RAM.
module tb_maze_wall_fetch;

  logic        clk;
  logic        rst_n;
  logic        de;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        line_start;
  logic [10:0] map_addr;
  logic        map_rdata;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic        cell_wall;
  logic        left;
  logic        top;
  logic        right;
  logic        bottom;
  logic        out_valid;
  logic        fetch_late;

`ifdef BORDER_WALL_EN
  localparam logic EB = 1'b1;
`else
  localparam logic EB = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic        mem [0:1199];
  logic [14:0] cap [0:639];
  logic [10:0] cap_addr [0:639];

  maze_wall_fetch #(.MAP_W(40), .MAP_H(30), .ADDR_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .px(px), .py(py), .line_start(line_start),
    .map_addr(map_addr), .map_rdata(map_rdata), .cell_x(cell_x), .cell_y(cell_y),
    .cell_wall(cell_wall), .left(left), .top(top), .right(right), .bottom(bottom),
    .out_valid(out_valid), .fetch_late(fetch_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) map_rdata <= (map_addr < 11'd1200) ? mem[map_addr] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1200; i++) mem[i] = 1'b0;
  endtask

  task automatic capture(input int p);
    cap[p]      = {out_valid, fetch_late, cell_wall, left, top, right, bottom, cell_x, cell_y};
    cap_addr[p] = map_addr;
  endtask

  // One 640-pixel line; de starts 'gap' clocks after line_start; rst_n low while px==rst_px.
  task automatic run_line(input int y, input int gap, input int rst_px);
    int prev;
    prev = -1;
    @(negedge clk);
    line_start = 1'b1; py = 10'(y); de = 1'b0; px = '0;
    repeat (gap - 1) begin
      @(negedge clk);
      line_start = 1'b0;
    end
    for (int p = 0; p < 640; p++) begin
      @(negedge clk);
      if (prev >= 0) capture(prev);
      line_start = 1'b0;
      de = 1'b1;
      px = 10'(p);
      rst_n = (p != rst_px);
      prev = p;
    end
    @(negedge clk);
    capture(prev);
    de = 1'b0; px = '0; rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; px = '0; py = '0; line_start = 1'b0;
    clear_map();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({cell_wall, left, top, right, bottom}), 32'd0);
    chk("rst_map_addr", 32'(map_addr), 32'd0);
    chk("rst_fetch_late", 32'(fetch_late), 32'd0);
    chk("rst_cell_xy", 32'({cell_x, cell_y}), 32'd0);
    rst_n = 1'b1;

    // Single wall at (5,3), line y=53 (row 3, cell_y 5).
    mem[3*40+5] = 1'b1;
    run_line(53, 10, -1);
    chk("t1_tile53", 32'(cap[87]), 32'({1'b1, 1'b0, 1'b1, 4'b0000, 4'd7, 4'd5}));
    chk("t1_tile43", 32'(cap[66]), 32'({1'b1, 1'b0, 1'b0, 4'b0010, 4'd2, 4'd5}));
    chk("t1_no_late", 32'(cap[639][13]), 32'd0);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t4_addr0", 32'(cap_addr[80]), 32'd126);
    chk("t4_addr1", 32'(cap_addr[81]), 32'd125);
    chk("t4_addr2", 32'(cap_addr[82]), 32'd86);
    chk("t4_addr3", 32'(cap_addr[83]), 32'd127);
    chk("t4_addr4", 32'(cap_addr[84]), 32'd166);

    // Walls (5,3),(6,3),(7,3).
    mem[3*40+6] = 1'b1;
    mem[3*40+7] = 1'b1;
    run_line(53, 10, -1);
    chk("t2_tile63", 32'(cap[99]), 32'({1'b1, 1'b0, 1'b1, 4'b1010, 4'd3, 4'd5}));

    // Only (0,0) set: border neighbours follow the configuration.
    clear_map();
    mem[0] = 1'b1;
    run_line(2, 10, -1);
    chk("t3_tile00", 32'(cap[4]), 32'({1'b1, 1'b0, 1'b1, EB, EB, 2'b00, 4'd4, 4'd2}));

    // line_start only 4 clocks before de: late at the first swap, sticky afterwards.
    clear_map();
    mem[3*40+5] = 1'b1;
    run_line(53, 4, -1);
    chk("t5_late_tile0", 32'(cap[0][13]), 32'd1);
    run_line(53, 10, -1);
    chk("t5_late_sticky", 32'(cap[639][13]), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t5_late_cleared", 32'(fetch_late), 32'd0);

    // One-clock reset in mid-line, then a clean line.
    run_line(53, 10, 200);
    chk("t6_before_rst", 32'(cap[199][14]), 32'd1);
    chk("t6_rst_outputs", 32'(cap[200]), 32'd0);
    chk("t6_rst_addr", 32'(cap_addr[200]), 32'd0);
    run_line(53, 10, -1);
    chk("t6_tile53", 32'(cap[87]), 32'({1'b1, 1'b0, 1'b1, 4'b0000, 4'd7, 4'd5}));
    chk("t6_tile43", 32'(cap[66]), 32'({1'b1, 1'b0, 1'b0, 4'b0010, 4'd2, 4'd5}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
